// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// Detects load-use and data-memory wait hazards, resolves taken jumps,
// drives the stage-register enables and flushes, and keeps stall/flush
// performance counters plus a sticky memory-timeout flag.
// Outputs are Mealy: combinational from the registered FSM state and the
// current pipeline inputs.

module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter logic [1:0]  LOAD_WBSEL   = 2'b01,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1_id,
    input  logic [4:0]       ID_rs2_id,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [4:0]       EX_rdst_id,
    input  logic             EX_we_reg,
    input  logic [1:0]       EX_wbsel,
    input  logic             EX_jump_taken,
    input  logic             MEM_dmem_req,
    input  logic             MEM_dmem_ready,
    output logic             pc_we,
    output logic             IFID_we,
    output logic             EXMEM_we,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic [1:0]       ctrl_state,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    // Remaining bubbles after the first one, loaded on entry to LDUSE.
    localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_BUBBLES - 1);
    // Wait-counter value whose increment reaches the timeout.
    localparam logic [7:0] WAIT_LAST   = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state_q;
    state_t     state_d;
    logic [1:0] bubble_q;
    logic [1:0] bubble_d;
    logic [7:0] wait_q;
    logic [7:0] wait_d;
    logic       err_set;

    logic       memwait;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       lduse;

    // Pre-reset versions of the control outputs.
    logic       c_pc_we;
    logic       c_ifid_we;
    logic       c_exmem_we;
    logic       c_ifid_flush;
    logic       c_idex_flush;

    // Hazard detection: outstanding memory access and load-use dependency.
    always_comb begin
        memwait = MEM_dmem_req & ~MEM_dmem_ready;
        rs1_hit = ID_use_rs1 & (ID_rs1_id == EX_rdst_id);
        rs2_hit = ID_use_rs2 & (ID_rs2_id == EX_rdst_id);
        lduse   = EX_we_reg & (EX_wbsel == LOAD_WBSEL) &
                  (EX_rdst_id != 5'd0) & (rs1_hit | rs2_hit);
    end

    // Next-state and control-output decode; jump beats load-use because the
    // dependent instruction is being squashed anyway.
    always_comb begin
        state_d      = state_q;
        bubble_d     = bubble_q;
        wait_d       = wait_q;
        err_set      = 1'b0;
        c_pc_we      = 1'b1;
        c_ifid_we    = 1'b1;
        c_exmem_we   = 1'b1;
        c_ifid_flush = 1'b0;
        c_idex_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (memwait) begin
                    c_pc_we    = 1'b0;
                    c_ifid_we  = 1'b0;
                    c_exmem_we = 1'b0;
                    state_d    = ST_MEMWAIT;
                    wait_d     = 8'd1;
                end else if (EX_jump_taken) begin
                    c_ifid_flush = 1'b1;
                    c_idex_flush = 1'b1;
                end else if (lduse) begin
                    c_pc_we      = 1'b0;
                    c_ifid_we    = 1'b0;
                    c_idex_flush = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        state_d  = ST_LDUSE;
                        bubble_d = BUBBLE_INIT;
                    end
                end
            end

            ST_LDUSE: begin
                if (memwait) begin
                    c_pc_we    = 1'b0;
                    c_ifid_we  = 1'b0;
                    c_exmem_we = 1'b0;
                end else if (EX_jump_taken) begin
                    c_ifid_flush = 1'b1;
                    c_idex_flush = 1'b1;
                    bubble_d     = 2'd0;
                    state_d      = ST_RUN;
                end else begin
                    c_pc_we      = 1'b0;
                    c_ifid_we    = 1'b0;
                    c_idex_flush = 1'b1;
                    bubble_d     = bubble_q - 2'd1;
                    if (bubble_q <= 2'd1) begin
                        bubble_d = 2'd0;
                        state_d  = ST_RUN;
                    end
                end
            end

            ST_MEMWAIT: begin
                if (!MEM_dmem_ready) begin
                    if (wait_q >= WAIT_LAST) begin
                        err_set = 1'b1;
                        wait_d  = 8'd0;
                        state_d = ST_RUN;
                    end else begin
                        c_pc_we    = 1'b0;
                        c_ifid_we  = 1'b0;
                        c_exmem_we = 1'b0;
                        wait_d     = wait_q + 8'd1;
                    end
                end else begin
                    wait_d  = 8'd0;
                    state_d = ST_RUN;
                    if (EX_jump_taken) begin
                        c_ifid_flush = 1'b1;
                        c_idex_flush = 1'b1;
                    end else if (lduse) begin
                        c_pc_we      = 1'b0;
                        c_ifid_we    = 1'b0;
                        c_idex_flush = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            state_d  = ST_LDUSE;
                            bubble_d = BUBBLE_INIT;
                        end
                    end
                end
            end

            default: begin
                state_d  = ST_RUN;
                bubble_d = 2'd0;
                wait_d   = 8'd0;
            end
        endcase
    end

    // Reset holds every stage and flushes IF/ID and ID/EX.
    always_comb begin
        pc_we      = rst ? 1'b0 : c_pc_we;
        IFID_we    = rst ? 1'b0 : c_ifid_we;
        EXMEM_we   = rst ? 1'b0 : c_exmem_we;
        IFID_flush = rst ? 1'b1 : c_ifid_flush;
        IDEX_flush = rst ? 1'b1 : c_idex_flush;
        ctrl_state = state_q;
    end

    // FSM state, bubble/wait counters and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            bubble_q <= 2'd0;
            wait_q   <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
            wait_q   <= wait_d;
            mem_err  <= mem_err | err_set;
        end
    end

    // Saturating performance counters for stalled and flushed cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!c_pc_we && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (c_ifid_flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of per-cycle stimulus
// patterns with expected control outputs, scored through a queue, plus a
// bounded memory-timeout sequence.

module tb_pipe_hazard_ctrl;

    // Stimulus pattern codes
    localparam int P_IDLE     = 0;
    localparam int P_HAZ1     = 1;
    localparam int P_HAZ_RD0  = 2;
    localparam int P_HAZ_NOU  = 3;
    localparam int P_HAZ2     = 4;
    localparam int P_JUMP     = 5;
    localparam int P_JUMP_HAZ = 6;
    localparam int P_HAZ_WB2  = 7;
    localparam int P_HAZ_NOWE = 8;
    localparam int P_MW       = 9;
    localparam int P_RDY      = 10;
    localparam int P_RDY_HAZ  = 11;
    localparam int P_RDY_JUMP = 12;

    // Expected {pc_we, IFID_we, EXMEM_we, IFID_flush, IDEX_flush}
    localparam logic [4:0] DEF = 5'b11100;
    localparam logic [4:0] RSO = 5'b00011;
    localparam logic [4:0] FRZ = 5'b00000;
    localparam logic [4:0] JMP = 5'b11111;
    localparam logic [4:0] BUB = 5'b00101;

    typedef struct {
        logic       rst;
        int         pat;
        logic [4:0] en;
        logic [1:0] st;
        logic       err;
        logic       d1_pc;
    } vec_t;

    typedef struct {
        int         idx;
        logic [4:0] en;
        logic [1:0] st;
        logic       err;
        logic [3:0] stall;
        logic [3:0] flush;
        logic       d1_pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [4:0]  ID_rs1_id;
    logic [4:0]  ID_rs2_id;
    logic        ID_use_rs1;
    logic        ID_use_rs2;
    logic [4:0]  EX_rdst_id;
    logic        EX_we_reg;
    logic [1:0]  EX_wbsel;
    logic        EX_jump_taken;
    logic        MEM_dmem_req;
    logic        MEM_dmem_ready;

    logic        pc_we, IFID_we, EXMEM_we, IFID_flush, IDEX_flush;
    logic [1:0]  ctrl_state;
    logic        mem_err;
    logic [3:0]  stall_cnt, flush_cnt;

    logic        d1_pc_we, d1_IFID_we, d1_EXMEM_we, d1_IFID_flush, d1_IDEX_flush;
    logic [1:0]  d1_ctrl_state;
    logic        d1_mem_err;
    logic [15:0] d1_stall_cnt, d1_flush_cnt;

    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[$];
    exp_t        sb[$];
    logic [3:0]  model_stall = 4'd0;
    logic [3:0]  model_flush = 4'd0;

    // Two-bubble, short-timeout, narrow-counter instance
    pipe_hazard_ctrl #(
        .LOAD_BUBBLES(2), .LOAD_WBSEL(2'b01), .MEM_TIMEOUT(4), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .ID_rs1_id(ID_rs1_id), .ID_rs2_id(ID_rs2_id),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_rdst_id(EX_rdst_id), .EX_we_reg(EX_we_reg), .EX_wbsel(EX_wbsel),
        .EX_jump_taken(EX_jump_taken),
        .MEM_dmem_req(MEM_dmem_req), .MEM_dmem_ready(MEM_dmem_ready),
        .pc_we(pc_we), .IFID_we(IFID_we), .EXMEM_we(EXMEM_we),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
        .ctrl_state(ctrl_state), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Default-parameter instance sharing the same inputs
    pipe_hazard_ctrl dut1 (
        .clk(clk), .rst(rst),
        .ID_rs1_id(ID_rs1_id), .ID_rs2_id(ID_rs2_id),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_rdst_id(EX_rdst_id), .EX_we_reg(EX_we_reg), .EX_wbsel(EX_wbsel),
        .EX_jump_taken(EX_jump_taken),
        .MEM_dmem_req(MEM_dmem_req), .MEM_dmem_ready(MEM_dmem_ready),
        .pc_we(d1_pc_we), .IFID_we(d1_IFID_we), .EXMEM_we(d1_EXMEM_we),
        .IFID_flush(d1_IFID_flush), .IDEX_flush(d1_IDEX_flush),
        .ctrl_state(d1_ctrl_state), .mem_err(d1_mem_err),
        .stall_cnt(d1_stall_cnt), .flush_cnt(d1_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input int p, input logic [4:0] en,
                                input logic [1:0] st, input logic err, input logic d1);
        vec_t v;
        v.rst = r; v.pat = p; v.en = en; v.st = st; v.err = err; v.d1_pc = d1;
        return v;
    endfunction

    task automatic checkVal(input string what, input int idx,
                            input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL row%0d %s: got %0h want %0h", idx, what, got, want);
        end
    endtask

    task automatic driveInputs(input int p, input logic r);
        rst            = r;
        ID_rs1_id      = 5'd1;
        ID_rs2_id      = 5'd2;
        ID_use_rs1     = 1'b1;
        ID_use_rs2     = 1'b1;
        EX_rdst_id     = 5'd7;
        EX_we_reg      = 1'b1;
        EX_wbsel       = 2'b00;
        EX_jump_taken  = 1'b0;
        MEM_dmem_req   = 1'b0;
        MEM_dmem_ready = 1'b0;
        if (p == P_HAZ1 || p == P_JUMP_HAZ || p == P_HAZ_WB2 || p == P_HAZ_NOWE ||
            p == P_HAZ_NOU || p == P_RDY_HAZ) begin
            EX_rdst_id = 5'd5;
            EX_wbsel   = 2'b01;
            ID_rs1_id  = 5'd5;
        end
        case (p)
            P_HAZ_RD0:  begin EX_rdst_id = 5'd0; EX_wbsel = 2'b01; ID_rs1_id = 5'd0; end
            P_HAZ_NOU:  ID_use_rs1 = 1'b0;
            P_HAZ2:     begin EX_rdst_id = 5'd5; EX_wbsel = 2'b01; ID_rs2_id = 5'd5; end
            P_JUMP:     EX_jump_taken = 1'b1;
            P_JUMP_HAZ: EX_jump_taken = 1'b1;
            P_HAZ_WB2:  EX_wbsel = 2'b10;
            P_HAZ_NOWE: EX_we_reg = 1'b0;
            P_MW:       MEM_dmem_req = 1'b1;
            P_RDY:      begin MEM_dmem_req = 1'b1; MEM_dmem_ready = 1'b1; end
            P_RDY_HAZ:  begin MEM_dmem_req = 1'b1; MEM_dmem_ready = 1'b1; end
            P_RDY_JUMP: begin MEM_dmem_req = 1'b1; MEM_dmem_ready = 1'b1;
                              EX_jump_taken = 1'b1; end
            default:    ;
        endcase
    endtask

    // Drive one cycle of stimulus and queue what the DUTs must show for it
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        driveInputs(v.pat, v.rst);
        e.idx = idx; e.en = v.en; e.st = v.st; e.err = v.err;
        e.stall = model_stall; e.flush = model_flush; e.d1_pc = v.d1_pc;
        sb.push_back(e);
        if (v.rst) begin
            model_stall = 4'd0;
            model_flush = 4'd0;
        end else begin
            if (!v.en[4] && model_stall != 4'hF) model_stall = model_stall + 4'd1;
            if (v.en[1] && model_flush != 4'hF) model_flush = model_flush + 4'd1;
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        #3;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue want entry");
        end else begin
            e = sb.pop_front();
            checkVal("outputs", e.idx,
                     {27'd0, pc_we, IFID_we, EXMEM_we, IFID_flush, IDEX_flush},
                     {27'd0, e.en});
            checkVal("ctrl_state", e.idx, {30'd0, ctrl_state}, {30'd0, e.st});
            checkVal("mem_err", e.idx, {31'd0, mem_err}, {31'd0, e.err});
            checkVal("stall_cnt", e.idx, {28'd0, stall_cnt}, {28'd0, e.stall});
            checkVal("flush_cnt", e.idx, {28'd0, flush_cnt}, {28'd0, e.flush});
            checkVal("dflt_pc_we", e.idx, {31'd0, d1_pc_we}, {31'd0, e.d1_pc});
        end
    endtask

    initial begin
        int n;
        bit seen;

        // Main table (state/err are the values before the row's clock edge)
        vecs.push_back(mk(1, P_IDLE,     RSO, 2'd0, 0, 0));
        vecs.push_back(mk(0, P_IDLE,     DEF, 2'd0, 0, 1));
        vecs.push_back(mk(0, P_HAZ1,     BUB, 2'd0, 0, 0));
        vecs.push_back(mk(0, P_IDLE,     BUB, 2'd1, 0, 1));
        vecs.push_back(mk(0, P_IDLE,     DEF, 2'd0, 0, 1));
        vecs.push_back(mk(0, P_HAZ_RD0,  DEF, 2'd0, 0, 1));
        vecs.push_back(mk(0, P_HAZ_NOU,  DEF, 2'd0, 0, 1));
        vecs.push_back(mk(0, P_JUMP_HAZ, JMP, 2'd0, 0, 1));
        vecs.push_back(mk(0, P_IDLE,     DEF, 2'd0, 0, 1));
        vecs.push_back(mk(0, P_HAZ2,     BUB, 2'd0, 0, 0));
        vecs.push_back(mk(0, P_JUMP,     JMP, 2'd1, 0, 1));
        vecs.push_back(mk(0, P_IDLE,     DEF, 2'd0, 0, 1));
        vecs.push_back(mk(0, P_HAZ_WB2,  DEF, 2'd0, 0, 1));
        vecs.push_back(mk(0, P_HAZ_NOWE, DEF, 2'd0, 0, 1));
        vecs.push_back(mk(0, P_MW,       FRZ, 2'd0, 0, 0));
        vecs.push_back(mk(0, P_MW,       FRZ, 2'd2, 0, 0));
        vecs.push_back(mk(0, P_MW,       FRZ, 2'd2, 0, 0));
        vecs.push_back(mk(0, P_RDY,      DEF, 2'd2, 0, 1));
        vecs.push_back(mk(0, P_IDLE,     DEF, 2'd0, 0, 1));
        vecs.push_back(mk(0, P_HAZ1,     BUB, 2'd0, 0, 0));
        vecs.push_back(mk(0, P_MW,       FRZ, 2'd1, 0, 0));
        vecs.push_back(mk(0, P_RDY,      BUB, 2'd1, 0, 1));
        vecs.push_back(mk(0, P_IDLE,     DEF, 2'd0, 0, 1));
        vecs.push_back(mk(0, P_MW,       FRZ, 2'd0, 0, 0));
        vecs.push_back(mk(0, P_RDY_HAZ,  BUB, 2'd2, 0, 0));
        vecs.push_back(mk(0, P_IDLE,     BUB, 2'd1, 0, 1));
        vecs.push_back(mk(0, P_MW,       FRZ, 2'd0, 0, 0));
        vecs.push_back(mk(0, P_RDY_JUMP, JMP, 2'd2, 0, 1));
        vecs.push_back(mk(0, P_IDLE,     DEF, 2'd0, 0, 1));
        vecs.push_back(mk(0, P_MW,       FRZ, 2'd0, 0, 0));
        vecs.push_back(mk(0, P_MW,       FRZ, 2'd2, 0, 0));
        vecs.push_back(mk(0, P_MW,       FRZ, 2'd2, 0, 0));
        vecs.push_back(mk(0, P_MW,       DEF, 2'd2, 0, 0));
        vecs.push_back(mk(0, P_MW,       FRZ, 2'd0, 1, 0));
        vecs.push_back(mk(1, P_MW,       RSO, 2'd2, 1, 0));
        vecs.push_back(mk(0, P_IDLE,     DEF, 2'd0, 0, 1));
        // Reset in the middle of a load-use stall
        vecs.push_back(mk(0, P_HAZ1,     BUB, 2'd0, 0, 0));
        vecs.push_back(mk(1, P_IDLE,     RSO, 2'd1, 0, 0));
        vecs.push_back(mk(0, P_IDLE,     DEF, 2'd0, 0, 1));

        driveInputs(P_IDLE, 1'b1);
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
            checkOutput();
        end

        // Memory never ready: three frozen cycles, then timeout cycle with defaults
        n = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            driveInputs(P_MW, 1'b0);
            #3;
            if (pc_we === 1'b1) begin
                seen = 1'b1;
                n = k;
                checkVal("timeout_state", 100, {30'd0, ctrl_state}, 32'd2);
                checkVal("timeout_err_pre", 100, {31'd0, mem_err}, 32'd0);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout_wait: got no release within 20 cycles want release on cycle 4");
        end else begin
            checkVal("timeout_cycles", 100, n, 32'd4);
        end
        @(posedge clk);
        #1;
        driveInputs(P_IDLE, 1'b0);
        #3;
        checkVal("timeout_err", 101, {31'd0, mem_err}, 32'd1);
        checkVal("timeout_run", 101, {30'd0, ctrl_state}, 32'd0);
        checkVal("timeout_pc_we", 101, {31'd0, pc_we}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
